// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and select-width helper for the mux family
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if: request/response bundle of the channel selector
// Ports: in_data/sel/mode/in_valid/in_ready request side,
//        out_data/out_sel/out_err/out_valid/out_ready response side, err_count status
interface mux_sel_pipe_if
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 31,
    parameter int WIDTH = 2,
    parameter int ERR_CNT_W = 8,
    localparam int SEL_W = sel_width(NUM_INPUTS)
);
    logic [NUM_INPUTS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0] sel;
    logic mode;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_sel;
    logic out_err;
    logic out_valid;
    logic out_ready;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_data, sel, mode, in_valid, out_ready,
        input in_ready, out_data, out_sel, out_err, out_valid, err_count
    );

    modport slave (
        input in_data, sel, mode, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid, err_count
    );
endinterface

// File: rtl/mux_sel_core.sv
// mux_sel_core: combinational N:1 channel pick with out-of-range flag
// Ports: in_data flattened channels, idx channel index, data picked value (0 on error), err idx >= NUM_INPUTS
module mux_sel_core
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 31,
    parameter int WIDTH = 2,
    localparam int SEL_W = sel_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            idx,
    output logic [WIDTH-1:0]            data,
    output logic                        err
);
    // Extra bit so a power-of-two channel count still compares correctly
    assign err = {1'b0, idx} >= (SEL_W+1)'(NUM_INPUTS);

    // Only real channels are decoded, so unused codes fall through to zero
    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_INPUTS; k++)
            if (idx == SEL_W'(k)) data = in_data[k*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N:1 channel selector, direct or round-robin scan, valid/ready both sides
// Ports: clk, reset (sync, active-high), bus (slave view of mux_sel_pipe_if)
module mux_sel_pipe
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 31,
    parameter int WIDTH = 2,
    parameter int ERR_CNT_W = 8,
    localparam int SEL_W = sel_width(NUM_INPUTS)
) (
    input logic           clk,
    input logic           reset,
    mux_sel_pipe_if.slave bus
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_INPUTS - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic out_err_q, out_err_d;
    logic out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] core_data;
    logic core_err;
    logic accept;
    logic scan;

    mux_sel_core #(.NUM_INPUTS(NUM_INPUTS), .WIDTH(WIDTH)) u_core (
        .in_data(bus.in_data),
        .idx(idx),
        .data(core_data),
        .err(core_err)
    );

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign bus.out_data = out_data_q;
    assign bus.out_sel = out_sel_q;
    assign bus.out_err = out_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_count = err_cnt_q;

    always_comb begin
        scan = bus.mode == MODE_SCAN;
        idx = (bus.mode == MODE_DIRECT) ? bus.sel : ptr_q;
        accept = bus.in_valid && bus.in_ready;
        // A drained result with no refill empties the register; a stalled one stays
        out_valid_d = accept || (out_valid_q && !bus.out_ready);
        out_data_d = accept ? core_data : out_data_q;
        out_sel_d = accept ? idx : out_sel_q;
        out_err_d = accept ? core_err : out_err_q;
        ptr_d = (accept && scan) ? ((ptr_q == LAST) ? '0 : ptr_q + 1'b1) : ptr_q;
        err_cnt_d = (accept && core_err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q <= '0;
            out_sel_q <= '0;
            out_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            ptr_q <= '0;
            err_cnt_q <= '0;
        end else begin
            out_data_q <= out_data_d;
            out_sel_q <= out_sel_d;
            out_err_q <= out_err_d;
            out_valid_q <= out_valid_d;
            ptr_q <= ptr_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule
